// File: rtl/instruction_memory_pkg.sv
// instruction_memory_pkg
//   Types shared by the instruction_memory refill responder.
//   imem_state_e : refill FSM states (wait for request, read beats,
//                  present the assembled line).
package instruction_memory_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        RESP = 2'd2
    } imem_state_e;

endpackage : instruction_memory_pkg

// File: rtl/instruction_memory_fifo.sv
// instruction_memory_fifo
//   Request queue for instruction_memory. Port-compatible subset of the
//   common_cells fifo_v3 with fall-through disabled: data_o always shows the
//   stored head entry, never the word being pushed in the same cycle.
//   clk_i   : clock
//   rst_ni  : asynchronous active-low reset (queue emptied)
//   full_o  : no free entry
//   empty_o : no stored entry
//   data_i  : entry to push
//   push_i  : push strobe (ignored while full)
//   data_o  : head entry
//   pop_i   : pop strobe (ignored while empty)
module instruction_memory_fifo #(
    parameter int unsigned DATA_WIDTH = 7,
    parameter int unsigned DEPTH      = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    output logic                  full_o,
    output logic                  empty_o,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  push_i,
    output logic [DATA_WIDTH-1:0] data_o,
    input  logic                  pop_i
);

    localparam int unsigned AddrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW  = $clog2(DEPTH + 1);
    localparam logic [AddrW-1:0] LastPtr = AddrW'(DEPTH - 1);
    localparam logic [CntW-1:0]  FullCnt = CntW'(DEPTH);

    logic [DEPTH-1:0][DATA_WIDTH-1:0] mem_q;
    logic [AddrW-1:0]                 wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]                  cnt_q;
    logic                             push_ok, pop_ok;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [AddrW-1:0] ptr_inc(input logic [AddrW-1:0] p);
        return (p == LastPtr) ? '0 : p + AddrW'(1);
    endfunction

    assign full_o  = (cnt_q == FullCnt);
    assign empty_o = (cnt_q == '0);
    assign data_o  = mem_q[rd_ptr_q];
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (pop_ok) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            if (push_ok && !pop_ok) begin
                cnt_q <= cnt_q + CntW'(1);
            end else if (pop_ok && !push_ok) begin
                cnt_q <= cnt_q - CntW'(1);
            end
        end
    end

endmodule : instruction_memory_fifo

// File: rtl/instruction_memory.sv
// instruction_memory
//   Instruction-cache refill responder. Queues cacheline read requests, reads
//   the line one word per cycle from a single-port word array, and presents
//   the whole line for one cycle on mem_valid_o. The same array is written by
//   the program-load port, which always wins and stalls an in-progress read.
//   clk_i        : clock
//   rst_ni       : asynchronous active-low reset
//   mem_req_i    : refill request valid
//   mem_addr_i   : cacheline address
//   mem_ready_o  : request accepted when mem_req_i && mem_ready_o
//   mem_valid_o  : one-cycle response strobe, no backpressure
//   mem_data_o   : line, word j = mem[addr*N+j], word 0 in the LSBs
//   prog_valid_i : program-load write strobe, always accepted
//   prog_addr_i  : program-load word address
//   prog_data_i  : program-load word data
module instruction_memory
    import instruction_memory_pkg::*;
#(
    parameter int unsigned PcWidth          = 9,
    parameter int unsigned CachelineIdxBits = 2,
    parameter int unsigned EncInstWidth     = 32,
    parameter int unsigned ReqFifoDepth     = 2
) (
    input  logic                                          clk_i,
    input  logic                                          rst_ni,
    input  logic                                          mem_req_i,
    input  logic [PcWidth-CachelineIdxBits-1:0]           mem_addr_i,
    output logic                                          mem_ready_o,
    output logic                                          mem_valid_o,
    output logic [(2**CachelineIdxBits)*EncInstWidth-1:0] mem_data_o,
    input  logic                                          prog_valid_i,
    input  logic [PcWidth-1:0]                            prog_addr_i,
    input  logic [EncInstWidth-1:0]                       prog_data_i
);

    localparam int unsigned N     = 2 ** CachelineIdxBits;
    localparam int unsigned LineW = PcWidth - CachelineIdxBits;
    localparam logic [CachelineIdxBits-1:0] LastBeat = '1;

    typedef logic [LineW-1:0]                 cache_addr_t;
    typedef logic [N-1:0][EncInstWidth-1:0]   line_t;

    imem_state_e                 state_q, state_d;
    cache_addr_t                 addr_q, addr_d, fifo_addr;
    logic [CachelineIdxBits-1:0] beat_q, beat_d;
    line_t                       line_q;
    logic                        fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic                        rd_en;
    logic [PcWidth-1:0]          rd_addr;
    logic [EncInstWidth-1:0]     mem_q [2**PcWidth];

    // Ready is forced low while reset is held; the queue itself only
    // contributes its registered full flag, so push and pop never race on full.
    assign mem_ready_o = rst_ni && !fifo_full;
    assign fifo_push   = mem_req_i && mem_ready_o;

    instruction_memory_fifo #(
        .DATA_WIDTH (LineW),
        .DEPTH      (ReqFifoDepth)
    ) u_req_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .data_i  (mem_addr_i),
        .push_i  (fifo_push),
        .data_o  (fifo_addr),
        .pop_i   (fifo_pop)
    );

    // addr*N + beat is a plain concatenation; it cannot overflow PcWidth.
    assign rd_addr = {addr_q, beat_q};

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        beat_d      = beat_q;
        fifo_pop    = 1'b0;
        rd_en       = 1'b0;
        mem_valid_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    addr_d   = fifo_addr;
                    beat_d   = '0;
                    state_d  = READ;
                end
            end
            READ: begin
                // A program write owns the single array port this cycle.
                if (!prog_valid_i) begin
                    rd_en  = 1'b1;
                    beat_d = beat_q + 1'b1;
                    if (beat_q == LastBeat) begin
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                mem_valid_o = 1'b1;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    addr_d   = fifo_addr;
                    beat_d   = '0;
                    state_d  = READ;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            addr_q  <= '0;
            beat_q  <= '0;
            line_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            beat_q  <= beat_d;
            if (rd_en) begin
                line_q[beat_q] <= mem_q[rd_addr];
            end
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (prog_valid_i) begin
            mem_q[prog_addr_i] <= prog_data_i;
        end
    end

    assign mem_data_o = line_q;

endmodule : instruction_memory

// File: tb/tb_instruction_memory.sv
module tb_instruction_memory;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         mem_req;
    logic [6:0]   mem_addr;
    logic         mem_ready;
    logic         mem_valid;
    logic [127:0] mem_data;
    logic         prog_valid;
    logic [8:0]   prog_addr;
    logic [31:0]  prog_data;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [31:0]  ref_mem [512];
    logic [127:0] resp_d [$];
    int           resp_c [$];
    logic [127:0] exp_q  [$];

    instruction_memory #(
        .PcWidth          (9),
        .CachelineIdxBits (2),
        .EncInstWidth     (32),
        .ReqFifoDepth     (2)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .mem_req_i    (mem_req),
        .mem_addr_i   (mem_addr),
        .mem_ready_o  (mem_ready),
        .mem_valid_o  (mem_valid),
        .mem_data_o   (mem_data),
        .prog_valid_i (prog_valid),
        .prog_addr_i  (prog_addr),
        .prog_data_i  (prog_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Response monitor: every strobe is captured with the cycle it was seen in.
    always @(negedge clk) begin
        if (mem_valid) begin
            resp_d.push_back(mem_data);
            resp_c.push_back(cyc);
        end
    end

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Expected line straight from the word-addressed memory image.
    function automatic logic [127:0] model_line(input int a);
        logic [127:0] r;
        for (int j = 0; j < 4; j++) r[j*32 +: 32] = ref_mem[a*4 + j];
        return r;
    endfunction

    // Called at a negedge. Returns at the negedge after the accepting edge,
    // acc = index of the accepting edge (equal to cyc on return).
    task automatic send_req(input int a, output int acc, output int stalls);
        stalls   = 0;
        mem_req  = 1'b1;
        mem_addr = 7'(a);
        for (int i = 0; i < 100; i++) begin
            if (mem_ready) break;
            stalls++;
            @(negedge clk);
        end
        check_eq("req_accept", 128'(mem_ready), 128'(1));
        acc = cyc + 1;
        @(negedge clk);
        mem_req = 1'b0;
    endtask

    task automatic wait_resp(output logic [127:0] d, output int c);
        for (int i = 0; i < 60; i++) begin
            if (resp_d.size() != 0) break;
            @(negedge clk);
        end
        check_eq("resp_arrived", 128'(resp_d.size() != 0), 128'(1));
        if (resp_d.size() != 0) begin
            d = resp_d.pop_front();
            c = resp_c.pop_front();
        end else begin
            d = 'x;
            c = -1000;
        end
    endtask

    task automatic prog_write(input int a, input logic [31:0] d);
        prog_valid = 1'b1;
        prog_addr  = 9'(a);
        prog_data  = d;
        ref_mem[a] = d;
        @(negedge clk);
        prog_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d failed so far", n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] d;
        int acc, st, c, gap;
        int acc_v [4];
        int st_v  [4];
        int c_v   [4];
        logic [31:0] new1, new2;

        rst_n = 1'b0; mem_req = 1'b0; mem_addr = '0;
        prog_valid = 1'b0; prog_addr = '0; prog_data = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check_eq("rst_ready", 128'(mem_ready), 128'(0));
        check_eq("rst_valid", 128'(mem_valid), 128'(0));
        check_eq("rst_data",  mem_data, 128'(0));
        rst_n = 1'b1;
        #1;
        check_eq("post_rst_ready", 128'(mem_ready), 128'(1));
        @(negedge clk);

        // Program load: mem[k] = A000_0000 + k
        for (int k = 0; k < 512; k++) begin
            prog_valid = 1'b1;
            prog_addr  = 9'(k);
            prog_data  = 32'hA000_0000 + 32'(k);
            ref_mem[k] = prog_data;
            @(negedge clk);
        end
        prog_valid = 1'b0;
        repeat (2) @(negedge clk);

        // Single request, addr 5: valid in cycle T+6 (T = accepting edge)
        send_req(5, acc, st);
        wait_resp(d, c);
        check_eq("lat_single", 128'(c - acc + 1), 128'(6));
        check_eq("data_addr5", d, 128'hA0000017_A0000016_A0000015_A0000014);
        check_eq("idle_valid", 128'(mem_valid), 128'(0));

        // Back-to-back requests; the fourth one must wait for a pop
        for (int i = 0; i < 4; i++) send_req(i, acc_v[i], st_v[i]);
        for (int i = 0; i < 4; i++) begin
            wait_resp(d, c_v[i]);
            check_eq("b2b_line", d, model_line(i));
        end
        check_eq("b2b_first_nostall", 128'(st_v[0]), 128'(0));
        check_eq("b2b_full_stall", 128'(st_v[3] > 0), 128'(1));
        check_eq("b2b_lat", 128'(c_v[0] - acc_v[0] + 1), 128'(6));
        for (int i = 1; i < 4; i++)
            check_eq("b2b_spacing", 128'(c_v[i] - c_v[i-1]), 128'(5));

        // Write hazard: write mem[0x15] while beat 0 is pending -> seen
        new1 = 32'h1234_5678;
        new2 = 32'hDEAD_BEEF;
        repeat (2) @(negedge clk);
        send_req(5, acc, st);
        @(negedge clk);
        prog_write(32'h15, new1);
        wait_resp(d, c);
        check_eq("hz_before_lat", 128'(c - acc + 1), 128'(7));
        check_eq("hz_before_data", d, 128'hA0000017_A0000016_12345678_A0000014);

        // Same write after beat 1 was read -> old value in the response
        repeat (2) @(negedge clk);
        send_req(5, acc, st);
        repeat (3) @(negedge clk);
        prog_write(32'h15, new2);
        wait_resp(d, c);
        check_eq("hz_after_lat", 128'(c - acc + 1), 128'(7));
        check_eq("hz_after_data", d, 128'hA0000017_A0000016_12345678_A0000014);

        // Reset mid-READ with one request queued
        repeat (2) @(negedge clk);
        send_req(1, acc, st);
        send_req(2, acc, st);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_ready", 128'(mem_ready), 128'(0));
        check_eq("midrst_valid", 128'(mem_valid), 128'(0));
        check_eq("midrst_data",  mem_data, 128'(0));
        repeat (2) @(negedge clk);
        resp_d.delete();
        resp_c.delete();
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check_eq("midrst_no_resp", 128'(resp_d.size()), 128'(0));
        check_eq("midrst_data_hold", mem_data, 128'(0));
        check_eq("midrst_ready_after", 128'(mem_ready), 128'(1));

        // Random stream: random program writes between bursts of random requests
        for (int ph = 0; ph < 8; ph++) begin
            for (int w = 0; w < 6; w++)
                prog_write(int'($urandom_range(0, 511)), $urandom);
            for (int r = 0; r < 16; r++) begin
                int a;
                a = int'($urandom_range(0, 127));
                send_req(a, acc, st);
                exp_q.push_back(model_line(a));
                gap = int'($urandom_range(0, 3));
                repeat (gap) @(negedge clk);
            end
            for (int r = 0; r < 16; r++) begin
                wait_resp(d, c);
                check_eq("rand_line", d, exp_q.pop_front());
            end
            repeat (2) @(negedge clk);
        end
        check_eq("rand_no_extra", 128'(resp_d.size()), 128'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_instruction_memory
